// File: rtl/vid_fifo_burst_arb.sv
// Round-robin AXI4 write-burst scheduler over CH_NUM prefetch video FIFOs.
// Each grant issues one AW, streams BURST_LEN beats from the granted FIFO,
// then waits for B and advances that channel's frame write pointer.
module vid_fifo_burst_arb #(
   parameter int unsigned CH_NUM      = 4,
   parameter int unsigned DATA_W      = 256,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned BURST_LEN   = 16,
   parameter int unsigned FRAME_BEATS = 64800
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [CH_NUM-1:0]          ch_burst_rdy,
   input  logic [CH_NUM*DATA_W-1:0]   ch_rd_data,
   input  logic [CH_NUM-1:0]          ch_rd_vld,
   output logic [CH_NUM-1:0]          ch_rd_en,
   input  logic [CH_NUM*ADDR_W-1:0]   ch_base_addr,
   input  logic [CH_NUM-1:0]          ch_frame_start,
   output logic [CH_NUM-1:0]          ch_frame_done,
   output logic [ADDR_W-1:0]          m_awaddr,
   output logic [7:0]                 m_awlen,
   output logic                       m_awvalid,
   input  logic                       m_awready,
   output logic [DATA_W-1:0]          m_wdata,
   output logic                       m_wlast,
   output logic                       m_wvalid,
   input  logic                       m_wready,
   input  logic [1:0]                 m_bresp,
   input  logic                       m_bvalid,
   output logic                       m_bready,
   output logic                       busy,
   output logic                       bresp_err
);

   localparam int unsigned GW      = $clog2(CH_NUM);
   localparam int unsigned OFF_W   = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
   localparam int unsigned CNT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned BYTE_SH = $clog2(DATA_W / 8);

   typedef enum logic [2:0] {S_IDLE, S_ARB, S_AW, S_W, S_B} state_t;

   state_t              state_q, state_d;
   logic [GW-1:0]       g_q, rr_q, arb_idx, cand, rr_next;
   logic                arb_found;
   logic [CNT_W-1:0]    cnt_q;
   logic [OFF_W-1:0]    off_q [CH_NUM];
   logic [CH_NUM-1:0]   pend_q;
   logic [ADDR_W-1:0]   awaddr_q;
   logic                bresp_err_q;
   logic                pop, b_done, restart, frame_end;
   logic [OFF_W:0]      off_sum;
   logic [ADDR_W-1:0]   arb_addr;
   logic [ADDR_W-1:0]   base_a [CH_NUM];
   logic [DATA_W-1:0]   data_a [CH_NUM];

   // Unpack the flat per-channel buses
   for (genvar i = 0; i < CH_NUM; i++) begin : g_unpack
      assign base_a[i] = ch_base_addr[i*ADDR_W +: ADDR_W];
      assign data_a[i] = ch_rd_data[i*DATA_W +: DATA_W];
   end

   assign m_awlen   = 8'(BURST_LEN - 1);
   assign m_awaddr  = awaddr_q;
   assign bresp_err = bresp_err_q;

   // First ready channel at or after rr, with wrap
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < CH_NUM; k++) begin
         cand = GW'((32'(rr_q) + k) % CH_NUM);
         if (!arb_found && ch_burst_rdy[cand]) begin
            arb_found = 1'b1;
            arb_idx   = cand;
         end
      end
      rr_next  = (arb_idx == GW'(CH_NUM - 1)) ? '0 : arb_idx + GW'(1);
      arb_addr = base_a[arb_idx] + (ADDR_W'(off_q[arb_idx]) << BYTE_SH);
   end

   // Pointer advance for the granted channel at B completion
   always_comb begin
      off_sum   = {1'b0, off_q[g_q]} + (OFF_W+1)'(BURST_LEN);
      frame_end = (off_sum == (OFF_W+1)'(FRAME_BEATS));
      restart   = pend_q[g_q] | ch_frame_start[g_q];
      b_done    = (state_q == S_B) && m_bvalid;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_d       = state_q;
      ch_rd_en      = '0;
      ch_frame_done = '0;
      m_awvalid     = 1'b0;
      m_wvalid      = 1'b0;
      m_wlast       = 1'b0;
      m_wdata       = '0;
      m_bready      = 1'b0;
      pop           = 1'b0;
      busy          = (state_q != S_IDLE);
      case (state_q)
         S_IDLE: if (|ch_burst_rdy) state_d = S_ARB;
         S_ARB:  state_d = arb_found ? S_AW : S_IDLE;
         S_AW: begin
            m_awvalid = 1'b1;
            if (m_awready) state_d = S_W;
         end
         S_W: begin
            m_wvalid      = ch_rd_vld[g_q];
            m_wdata       = data_a[g_q];
            m_wlast       = (cnt_q == CNT_W'(BURST_LEN - 1));
            pop           = m_wready & ch_rd_vld[g_q];
            ch_rd_en[g_q] = pop;
            if (pop && m_wlast) state_d = S_B;
         end
         S_B: begin
            m_bready = 1'b1;
            if (m_bvalid) begin
               state_d            = S_IDLE;
               ch_frame_done[g_q] = frame_end & ~restart;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Grant, beat counter, frame pointers and error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         g_q         <= '0;
         rr_q        <= '0;
         cnt_q       <= '0;
         awaddr_q    <= '0;
         pend_q      <= '0;
         bresp_err_q <= 1'b0;
         for (int i = 0; i < CH_NUM; i++) off_q[i] <= '0;
      end else begin
         if (state_q == S_ARB && arb_found) begin
            g_q      <= arb_idx;
            rr_q     <= rr_next;
            awaddr_q <= arb_addr;
         end
         if (pop) cnt_q <= m_wlast ? '0 : cnt_q + CNT_W'(1);
         if (b_done && m_bresp != 2'b00) bresp_err_q <= 1'b1;
         for (int i = 0; i < CH_NUM; i++) begin
            if (b_done && g_q == GW'(i)) begin
               pend_q[i] <= 1'b0;
               off_q[i]  <= (restart || frame_end) ? '0 : off_sum[OFF_W-1:0];
            end else if (ch_frame_start[i]) begin
               if (g_q == GW'(i) && (state_q == S_AW || state_q == S_W || state_q == S_B))
                  pend_q[i] <= 1'b1;
               else
                  off_q[i] <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_vid_fifo_burst_arb.sv
// Directed bench for vid_fifo_burst_arb: a burst table drives grants,
// addresses, beat streams, B responses and frame-pointer corner cases.
`timescale 1ns/1ps
module tb_vid_fifo_burst_arb;

   localparam int unsigned CH_NUM      = 4;
   localparam int unsigned DATA_W      = 256;
   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned BURST_LEN   = 16;
   localparam int unsigned FRAME_BEATS = 32;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [CH_NUM-1:0]        ch_burst_rdy;
   logic [CH_NUM*DATA_W-1:0] ch_rd_data;
   logic [CH_NUM-1:0]        ch_rd_vld;
   logic [CH_NUM-1:0]        ch_rd_en;
   logic [CH_NUM*ADDR_W-1:0] ch_base_addr;
   logic [CH_NUM-1:0]        ch_frame_start;
   logic [CH_NUM-1:0]        ch_frame_done;
   logic [ADDR_W-1:0]        m_awaddr;
   logic [7:0]               m_awlen;
   logic                     m_awvalid, m_awready;
   logic [DATA_W-1:0]        m_wdata;
   logic                     m_wlast, m_wvalid, m_wready;
   logic [1:0]               m_bresp;
   logic                     m_bvalid, m_bready;
   logic                     busy, bresp_err;

   int n_checks = 0;
   int n_fail   = 0;
   int unsigned pop_cnt [CH_NUM];
   int unsigned exp_idx [CH_NUM];
   logic exp_err = 1'b0;

   typedef struct {
      logic [CH_NUM-1:0] rdy;
      int unsigned       ch;
      logic [ADDR_W-1:0] addr;
      logic              done;
      logic [1:0]        bresp;
      int unsigned       mode;  // 0 plain, 1 back-pressure, 2 frame_start in W, 3 reset in W, 4 frame_start while idle
   } vec_t;
   vec_t vecs [$];

   vid_fifo_burst_arb #(
      .CH_NUM(CH_NUM), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
      .BURST_LEN(BURST_LEN), .FRAME_BEATS(FRAME_BEATS)
   ) dut (
      .clk(clk), .rst(rst),
      .ch_burst_rdy(ch_burst_rdy), .ch_rd_data(ch_rd_data), .ch_rd_vld(ch_rd_vld),
      .ch_rd_en(ch_rd_en), .ch_base_addr(ch_base_addr), .ch_frame_start(ch_frame_start),
      .ch_frame_done(ch_frame_done), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata),
      .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .busy(busy), .bresp_err(bresp_err)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] mk_word(input int unsigned c, input int unsigned n);
      return {{(DATA_W-32){1'b0}}, 8'(c), 24'(n)};
   endfunction

   function automatic logic [CH_NUM-1:0] onehot(input int unsigned c);
      logic [CH_NUM-1:0] v;
      v = '0;
      v[c] = 1'b1;
      return v;
   endfunction

   // FIFO model: each channel presents an incrementing, channel-tagged word
   for (genvar c = 0; c < CH_NUM; c++) begin : g_fifo
      assign ch_rd_data[c*DATA_W +: DATA_W] = mk_word(c, pop_cnt[c]);
   end
   assign ch_base_addr = {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000};

   always @(posedge clk) begin
      for (int c = 0; c < CH_NUM; c++)
         if (ch_rd_en[c] && ch_rd_vld[c]) pop_cnt[c] <= pop_cnt[c] + 1;
   end

   task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},   busy, 0);
      check({tag, "_awv"},    m_awvalid, 0);
      check({tag, "_awaddr"}, m_awaddr, 0);
      check({tag, "_wv"},     m_wvalid, 0);
      check({tag, "_wlast"},  m_wlast, 0);
      check({tag, "_wdata"},  m_wdata, 0);
      check({tag, "_bready"}, m_bready, 0);
      check({tag, "_rd_en"},  ch_rd_en, 0);
      check({tag, "_fdone"},  ch_frame_done, 0);
      check({tag, "_berr"},   bresp_err, 0);
   endtask

   task automatic add(input logic [CH_NUM-1:0] rdy, input int unsigned ch, input logic [ADDR_W-1:0] addr,
                      input logic done, input logic [1:0] bresp, input int unsigned mode);
      vec_t v;
      v.rdy = rdy; v.ch = ch; v.addr = addr; v.done = done; v.bresp = bresp; v.mode = mode;
      vecs.push_back(v);
   endtask

   // One full burst; entered and left on a negedge with the DUT idle
   task automatic run_burst(input vec_t v);
      int cyc, beats;
      logic wr, vl;
      if (v.mode == 4) begin
         ch_frame_start = onehot(v.ch);
         @(negedge clk);
         ch_frame_start = '0;
      end
      ch_burst_rdy = v.rdy;
      cyc = 0;
      #1;
      while (!m_awvalid && cyc < 10) begin
         @(negedge clk); #1; cyc++;
      end
      check("aw_seen", m_awvalid, 1);
      if (!m_awvalid) return;
      check("awaddr", m_awaddr, v.addr);
      check("awlen", m_awlen, BURST_LEN - 1);
      check("w_before_aw", m_wvalid, 0);
      @(negedge clk); #1;
      check("aw_hold_valid", m_awvalid, 1);
      check("aw_hold_addr", m_awaddr, v.addr);
      m_awready = 1'b1;
      ch_burst_rdy = '0;
      @(negedge clk);
      m_awready = 1'b0;
      beats = 0;
      cyc = 0;
      while (beats < BURST_LEN && cyc < 64) begin
         if (v.mode == 3 && beats == 4) begin
            m_wready = 1'b0;
            rst = 1'b1;
            #1;
            check_idle_outputs("rst_mid_w");
            exp_err = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            #1;
            check("after_rst_busy", busy, 0);
            return;
         end
         wr = (v.mode == 1) ? (cyc % 2 == 0) : 1'b1;
         vl = (v.mode == 1) ? !(cyc >= 5 && cyc <= 7) : 1'b1;
         m_wready = wr;
         ch_rd_vld = {CH_NUM{vl}};
         ch_frame_start = (v.mode == 2 && cyc == 2) ? onehot(v.ch) : '0;
         #1;
         check("wvalid", m_wvalid, vl);
         check("rd_en", ch_rd_en, (wr && vl) ? onehot(v.ch) : '0);
         if (wr && vl) begin
            check("wdata", m_wdata, mk_word(v.ch, exp_idx[v.ch]));
            check("wlast", m_wlast, beats == BURST_LEN - 1);
            exp_idx[v.ch]++;
            beats++;
         end
         @(negedge clk);
         cyc++;
      end
      m_wready = 1'b0;
      ch_frame_start = '0;
      ch_rd_vld = '1;
      check("beat_count", beats, BURST_LEN);
      if (v.mode == 0) check("w_cycles", cyc, BURST_LEN);
      #1;
      check("b_bready", m_bready, 1);
      check("b_wvalid", m_wvalid, 0);
      check("b_rd_en", ch_rd_en, 0);
      check("b_fdone_early", ch_frame_done, 0);
      m_bvalid = 1'b1;
      m_bresp = v.bresp;
      #1;
      check("frame_done", ch_frame_done, v.done ? onehot(v.ch) : '0);
      @(negedge clk);
      m_bvalid = 1'b0;
      m_bresp = 2'b00;
      if (v.bresp != 2'b00) exp_err = 1'b1;
      #1;
      check("post_b_busy", busy, 0);
      check("post_b_fdone", ch_frame_done, 0);
      check("bresp_err", bresp_err, exp_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      ch_burst_rdy = '0; ch_rd_vld = '1; ch_frame_start = '0;
      m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 1'b0;
      @(negedge clk); #1;
      check("idle_no_rdy", busy, 0);

      add(4'b0001, 0, 32'h1000_0000, 0, 2'b00, 0);
      add(4'b0001, 0, 32'h1000_0200, 1, 2'b00, 0);
      add(4'b1000, 3, 32'h4000_0000, 0, 2'b00, 0);
      add(4'b1111, 0, 32'h1000_0000, 0, 2'b00, 0);
      add(4'b1111, 1, 32'h2000_0000, 0, 2'b00, 0);
      add(4'b1111, 2, 32'h3000_0000, 0, 2'b00, 0);
      add(4'b1111, 3, 32'h4000_0200, 1, 2'b00, 0);
      add(4'b1111, 0, 32'h1000_0200, 1, 2'b00, 0);
      add(4'b1111, 1, 32'h2000_0200, 1, 2'b00, 0);
      add(4'b1111, 2, 32'h3000_0200, 1, 2'b00, 0);
      add(4'b1111, 3, 32'h4000_0000, 0, 2'b00, 0);
      add(4'b0010, 1, 32'h2000_0000, 0, 2'b00, 1);
      add(4'b0100, 2, 32'h3000_0000, 0, 2'b00, 0);
      add(4'b0100, 2, 32'h3000_0200, 1, 2'b00, 0);
      add(4'b0100, 2, 32'h3000_0000, 0, 2'b00, 0);
      add(4'b0010, 1, 32'h2000_0200, 0, 2'b00, 2);
      add(4'b0010, 1, 32'h2000_0000, 0, 2'b00, 0);
      add(4'b0001, 0, 32'h1000_0000, 0, 2'b10, 0);
      add(4'b0101, 2, 32'h3000_0200, 1, 2'b00, 0);
      add(4'b0011, 0, 32'h1000_0200, 1, 2'b00, 0);
      add(4'b1000, 3, 32'h4000_0000, 0, 2'b00, 4);
      add(4'b0001, 0, 32'h1000_0000, 0, 2'b00, 3);
      add(4'b1111, 0, 32'h1000_0000, 0, 2'b00, 0);
      add(4'b1111, 1, 32'h2000_0000, 0, 2'b00, 0);

      foreach (vecs[i]) run_burst(vecs[i]);

      // No request pending: the block must stay idle
      repeat (3) @(negedge clk);
      #1;
      check("final_idle", busy, 0);
      check("final_awvalid", m_awvalid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
